regfile_multi: RTL and testbench

REGFILE_MULTI -- requirements
Module: regfile_multi

---
 rtl/regfile_multi.sv | 93 +++++++++
 tb/tb_regfile_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multi.sv
// Multi-port register file: one write port, two combinational read ports, per-entry
// valid bits and a clear sweep of DEPTH cycles. Define REGFILE_BYPASS_EN to forward writes to the read ports.
module regfile_multi #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [WIDTH-1:0]  data_out_a,
    output logic [WIDTH-1:0]  data_out_b,
    output logic              valid_a,
    output logic              valid_b,
    input  logic              clear,
    output logic              busy,
    output logic              write_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] sweep_idx;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              write_ok;

    // Reset is folded in so the forwarding path stays quiet while reset is held.
    assign write_ok = write && (state == IDLE) && !reset;
    assign busy     = (state == SWEEP);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = SWEEP;
            SWEEP:   if (sweep_idx == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sweep_idx  <= '0;
            write_drop <= 1'b0;
            valid      <= '0;
            // NOTE: storage is reset because a reset must immediately read back as zero.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            write_drop <= write && (state == SWEEP);
            sweep_idx  <= (state == IDLE) ? '0 : sweep_idx + ADDR_W'(1);
            if (write_ok) begin
                regs[writenum]  <= data_in;
                valid[writenum] <= 1'b1;
            end
            if (state == SWEEP) begin
                regs[sweep_idx]  <= '0;
                valid[sweep_idx] <= 1'b0;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    assign fwd_a      = write_ok && (writenum == readnum_a);
    assign fwd_b      = write_ok && (writenum == readnum_b);
    assign data_out_a = fwd_a ? data_in : regs[readnum_a];
    assign data_out_b = fwd_b ? data_in : regs[readnum_b];
    assign valid_a    = fwd_a | valid[readnum_a];
    assign valid_b    = fwd_b | valid[readnum_b];
`else
    assign data_out_a = regs[readnum_a];
    assign data_out_b = regs[readnum_b];
    assign valid_a    = valid[readnum_a];
    assign valid_b    = valid[readnum_b];
`endif

endmodule

// File: tb/tb_regfile_multi.sv
// Directed self-checking bench for regfile_multi: default 16x8 instance plus a 32x16 instance.
module tb_regfile_multi;

    logic        clk;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [15:0] data_out_a;
    logic [15:0] data_out_b;
    logic        valid_a;
    logic        valid_b;
    logic        clear;
    logic        busy;
    logic        write_drop;

    logic        w_write;
    logic [3:0]  w_writenum;
    logic [31:0] w_data_in;
    logic [3:0]  w_readnum_a;
    logic [3:0]  w_readnum_b;
    logic [31:0] w_data_out_a;
    logic [31:0] w_data_out_b;
    logic        w_valid_a;
    logic        w_valid_b;
    logic        w_clear;
    logic        w_busy;
    logic        w_write_drop;

    int checks = 0;
    int errors = 0;

    regfile_multi dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .writenum   (writenum),
        .data_in    (data_in),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .valid_a    (valid_a),
        .valid_b    (valid_b),
        .clear      (clear),
        .busy       (busy),
        .write_drop (write_drop)
    );

    regfile_multi #(.WIDTH(32), .ADDR_W(4)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .write      (w_write),
        .writenum   (w_writenum),
        .data_in    (w_data_in),
        .readnum_a  (w_readnum_a),
        .readnum_b  (w_readnum_b),
        .data_out_a (w_data_out_a),
        .data_out_b (w_data_out_b),
        .valid_a    (w_valid_a),
        .valid_b    (w_valid_b),
        .clear      (w_clear),
        .busy       (w_busy),
        .write_drop (w_write_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (write_drop !== 1'b0) begin errors++; $display("FAIL reset_write_drop: got %b expected 0", write_drop); end
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            #1;
            checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL reset_read_a[%0d]: got %h/%b expected 0000/0", i, data_out_a, valid_a); end
            checks++; if (data_out_b !== 16'h0000 || valid_b !== 1'b0) begin errors++; $display("FAIL reset_read_b[%0d]: got %h/%b expected 0000/0", 7 - i, data_out_b, valid_b); end
        end
    endtask

    task automatic test_single_write();
        write = 1'b1; writenum = 3'd0; data_in = 16'h0003; readnum_a = 3'd0;
        #1;
`ifndef REGFILE_BYPASS_EN
        checks++; if (data_out_a !== 16'h0000) begin errors++; $display("FAIL single_write_pre_edge: got %h expected 0000", data_out_a); end
`endif
        tick();
        write = 1'b0;
        #1;
        checks++; if (data_out_a !== 16'h0003) begin errors++; $display("FAIL single_write_data: got %h expected 0003", data_out_a); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_write_valid: got %b expected 1", valid_a); end
    endtask

    task automatic test_dual_read();
        write = 1'b1; writenum = 3'd5; data_in = 16'hBEEF;
        tick();
        writenum = 3'd2; data_in = 16'h1234;
        tick();
        write = 1'b0; readnum_a = 3'd5; readnum_b = 3'd2;
        #1;
        checks++; if (data_out_a !== 16'hBEEF) begin errors++; $display("FAIL dual_read_a: got %h expected beef", data_out_a); end
        checks++; if (data_out_b !== 16'h1234) begin errors++; $display("FAIL dual_read_b: got %h expected 1234", data_out_b); end
        readnum_b = 3'd5;
        #1;
        checks++; if (data_out_a !== 16'hBEEF || data_out_b !== 16'hBEEF) begin errors++; $display("FAIL same_addr_read: got %h/%h expected beef/beef", data_out_a, data_out_b); end
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL same_addr_valid: got %b expected 1", valid_b); end
        readnum_a = 3'd4;
        #1;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL unwritten_valid: got %b expected 0", valid_a); end
    endtask

    task automatic test_clear_sweep();
        int cycles;
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; writenum = 3'(i); data_in = 16'(16'h1000 + i);
            tick();
        end
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            #1;
            checks++; if (data_out_a !== 16'(16'h1000 + i) || valid_a !== 1'b1) begin errors++; $display("FAIL fill_read[%0d]: got %h/%b expected %h/1", i, data_out_a, valid_a, 16'(16'h1000 + i)); end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            if (cycles == 3) begin
                checks++; if (write_drop !== 1'b1) begin errors++; $display("FAIL sweep_write_drop: got %b expected 1", write_drop); end
                readnum_b = 3'd7; readnum_a = 3'd1;
                #1;
                checks++; if (data_out_b !== 16'h1007 || valid_b !== 1'b1) begin errors++; $display("FAIL sweep_drop_storage: got %h/%b expected 1007/1", data_out_b, valid_b); end
                checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL sweep_swept_entry: got %h/%b expected 0000/0", data_out_a, valid_a); end
            end else begin
                checks++; if (write_drop !== 1'b0) begin errors++; $display("FAIL sweep_no_drop[%0d]: got %b expected 0", cycles, write_drop); end
            end
            write = (cycles == 2); writenum = 3'd7; data_in = 16'hDEAD;
            clear = (cycles == 4);
            tick();
            cycles++;
        end
        write = 1'b0; clear = 1'b0;
        checks++; if (cycles !== 8) begin errors++; $display("FAIL sweep_length: got %0d expected 8", cycles); end
        checks++; if (write_drop !== 1'b0) begin errors++; $display("FAIL post_sweep_drop: got %b expected 0", write_drop); end
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            #1;
            checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL post_sweep_read[%0d]: got %h/%b expected 0000/0", i, data_out_a, valid_a); end
        end
    endtask

    task automatic test_clear_with_write();
        int cycles;
        write = 1'b1; writenum = 3'd4; data_in = 16'h4444; clear = 1'b1;
        tick();
        write = 1'b0; clear = 1'b0; readnum_a = 3'd4;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_write_busy: got %b expected 1", busy); end
        checks++; if (data_out_a !== 16'h4444 || valid_a !== 1'b1) begin errors++; $display("FAIL clear_write_accepted: got %h/%b expected 4444/1", data_out_a, valid_a); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        checks++; if (cycles !== 8) begin errors++; $display("FAIL clear_write_length: got %0d expected 8", cycles); end
        checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL clear_write_swept: got %h/%b expected 0000/0", data_out_a, valid_a); end
    endtask

    task automatic test_reset_mid_sweep();
        write = 1'b1; writenum = 3'd0; data_in = 16'h0A0A;
        tick();
        writenum = 3'd7; data_in = 16'h0707;
        tick();
        write = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();
        readnum_a = 3'd7; readnum_b = 3'd0;
        #1;
        checks++; if (busy !== 1'b1 || data_out_a !== 16'h0707) begin errors++; $display("FAIL mid_sweep_state: got %b/%h expected 1/0707", busy, data_out_a); end
        checks++; if (data_out_b !== 16'h0000) begin errors++; $display("FAIL mid_sweep_swept: got %h expected 0000", data_out_b); end
        #1 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || write_drop !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl: got busy %b drop %b expected 0/0", busy, write_drop); end
        checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL async_reset_data: got %h/%b expected 0000/0", data_out_a, valid_a); end
        write = 1'b1; writenum = 3'd6; data_in = 16'h6666; clear = 1'b1; readnum_a = 3'd6;
        #1;
        checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL reset_no_forward: got %h/%b expected 0000/0", data_out_a, valid_a); end
        tick();
        write = 1'b0; clear = 1'b0;
        #1 reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_clear_ignored: got %b expected 0", busy); end
        checks++; if (data_out_a !== 16'h0000 || valid_a !== 1'b0) begin errors++; $display("FAIL reset_write_ignored: got %h/%b expected 0000/0", data_out_a, valid_a); end
        write = 1'b1; writenum = 3'd7; data_in = 16'h7777;
        tick();
        write = 1'b0; readnum_a = 3'd7;
        #1;
        checks++; if (data_out_a !== 16'h7777 || valid_a !== 1'b1) begin errors++; $display("FAIL post_reset_write: got %h/%b expected 7777/1", data_out_a, valid_a); end
    endtask

    task automatic test_bypass();
        write = 1'b1; writenum = 3'd3; data_in = 16'h0033;
        tick();
        data_in = 16'h00AA; readnum_a = 3'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (data_out_a !== 16'h00AA || valid_a !== 1'b1) begin errors++; $display("FAIL bypass_pre_edge: got %h/%b expected 00aa/1", data_out_a, valid_a); end
`else
        checks++; if (data_out_a !== 16'h0033 || valid_a !== 1'b1) begin errors++; $display("FAIL no_bypass_pre_edge: got %h/%b expected 0033/1", data_out_a, valid_a); end
`endif
        tick();
        write = 1'b0;
        #1;
        checks++; if (data_out_a !== 16'h00AA || valid_a !== 1'b1) begin errors++; $display("FAIL bypass_post_edge: got %h/%b expected 00aa/1", data_out_a, valid_a); end
    endtask

    task automatic test_wide();
        int cycles;
        w_write = 1'b1; w_writenum = 4'd15; w_data_in = 32'hFFFF_0001;
        tick();
        w_writenum = 4'd14; w_data_in = 32'h8000_0000;
        tick();
        w_write = 1'b0; w_readnum_a = 4'd15; w_readnum_b = 4'd14;
        #1;
        checks++; if (w_data_out_a !== 32'hFFFF_0001 || w_valid_a !== 1'b1) begin errors++; $display("FAIL wide_read_15: got %h/%b expected ffff0001/1", w_data_out_a, w_valid_a); end
        checks++; if (w_data_out_b !== 32'h8000_0000) begin errors++; $display("FAIL wide_read_14: got %h expected 80000000", w_data_out_b); end
        w_clear = 1'b1;
        tick();
        w_clear = 1'b0;
        cycles = 0;
        while (w_busy === 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        checks++; if (cycles !== 16) begin errors++; $display("FAIL wide_sweep_length: got %0d expected 16", cycles); end
        checks++; if (w_data_out_a !== 32'h0 || w_valid_a !== 1'b0) begin errors++; $display("FAIL wide_post_sweep: got %h/%b expected 00000000/0", w_data_out_a, w_valid_a); end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
        readnum_a = '0; readnum_b = '0; clear = 1'b0;
        w_write = 1'b0; w_writenum = '0; w_data_in = '0;
        w_readnum_a = '0; w_readnum_b = '0; w_clear = 1'b0;
        test_reset();
        test_single_write();
        test_dual_read();
        test_clear_sweep();
        test_clear_with_write();
        test_reset_mid_sweep();
        test_bypass();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
